// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunked adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Chunk index width; at least one bit even when there is a single chunk.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder built from fa cells.
// Also exports the carry into the slice MSB so the top can derive signed overflow.
module addsub_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic [CHUNK-1:0] i_y,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa u_fa (
      .i_x   (i_x[i]),
      .i_y   (i_y[i]),
      .i_cin (w_c[i]),
      .o_sum (o_sum[i]),
      .o_cout(w_c[i+1])
    );
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_x ^ i_y ^ i_cin;
  assign o_cout = (i_x & i_y) | (i_cin & (i_x ^ i_y));

endmodule

// File: rtl/chunk_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// carry chained through a register. Valid/ready on both operand and result sides.
module chunk_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_borrow,
  output logic             o_ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_e           r_state, w_state_next;
  logic             r_in_ready, r_out_valid;
  logic             w_accept, w_last;

  logic [WIDTH-1:0] r_a, r_b, r_part;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry, r_mode;

  logic [WIDTH-1:0] r_result;
  logic             r_cout, r_borrow, r_ovf;

  logic [CHUNK-1:0] w_x, w_y, w_sum;
  logic             w_scout, w_cmsb;
  logic [WIDTH-1:0] w_full;

  // FSM state register; handshake flags are registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == DONE);
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = BUSY;
      BUSY:    if (r_idx == LAST_IDX) w_state_next = DONE;
      DONE:    if (i_out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM decoded strobes for the datapath
  always_comb begin
    w_accept = (r_state == IDLE) & r_in_ready & i_in_valid;
    w_last   = (r_state == BUSY) & (r_idx == LAST_IDX);
  end

  // Select the operand slices addressed by the chunk index
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_x = r_a[k*CHUNK +: CHUNK];
        w_y = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  // Merge the current slice sum into the partial result
  always_comb begin
    w_full = r_part;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) w_full[k*CHUNK +: CHUNK] = w_sum;
    end
  end

  addsub_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_scout),
    .o_cmsb(w_cmsb)
  );

  // Operand capture on accept (b pre-inverted for subtract), then per-chunk accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_mode  <= MODE_ADD;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b ^ {WIDTH{i_mode == MODE_SUB}};
      r_part  <= '0;
      r_idx   <= '0;
      r_carry <= i_mode;
      r_mode  <= i_mode;
    end else if (r_state == BUSY) begin
      r_part  <= w_full;
      r_carry <= w_scout;
      r_idx   <= r_idx + IDXW'(1);
    end
  end

  // Result and flags update only on the final chunk and hold until the next one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_last) begin
      r_result <= w_full;
      r_cout   <= w_scout;
      r_borrow <= r_mode & ~w_scout;
      // Carry into MSB differing from carry out of MSB marks signed overflow
      r_ovf    <= w_cmsb ^ w_scout;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_cout      = r_cout;
  assign o_borrow    = r_borrow;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_chunk_addsub.sv
// Bench for chunk_addsub: directed checks on a 16/4 instance, random model checks on
// 8/8 and 32/4 instances.
`timescale 1ns/1ps
module tb_chunk_addsub;

  localparam int NOPS = 1000;

  logic clk;
  logic rst_n;
  bit   start;
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(input int w, input longint unsigned x, input longint unsigned y,
                                input bit m, output longint unsigned r, output bit c,
                                output bit bo, output bit ov);
    longint unsigned md;
    longint          sx, sy, s, half;
    md   = 64'd1 << w;
    half = longint'(md / 2);
    sx   = (x >= md / 2) ? longint'(x) - longint'(md) : longint'(x);
    sy   = (y >= md / 2) ? longint'(y) - longint'(md) : longint'(y);
    s    = m ? sx - sy : sx + sy;
    r    = (m ? x - y : x + y) & (md - 1);
    c    = m ? (x >= y) : ((x + y) >= md);
    bo   = m & !c;
    ov   = (s < -half) || (s >= half);
  endfunction

  function automatic longint unsigned pick(input int w);
    longint unsigned msk;
    msk = (64'd1 << w) - 1;
    case ($urandom_range(7))
      0:       return 0;
      1:       return msk;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 1;
      default: return {$urandom(), $urandom()} & msk;
    endcase
  endfunction

  // ---------------- directed instance: WIDTH=16, CHUNK=4 ----------------
  logic        d_iv, d_ordy, d_mode, d_ir, d_ov, d_co, d_bo, d_of;
  logic [15:0] d_a, d_b, d_res;

  chunk_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (d_iv),
    .o_in_ready (d_ir),
    .i_a        (d_a),
    .i_b        (d_b),
    .i_mode     (d_mode),
    .o_out_valid(d_ov),
    .i_out_ready(d_ordy),
    .o_result   (d_res),
    .o_cout     (d_co),
    .o_borrow   (d_bo),
    .o_ovf      (d_of)
  );

  // Present one operation and return just after its accept edge
  task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input bit xm);
    int n;
    n = 0;
    @(negedge clk);
    while (!d_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_in_ready", d_ir, 1);
    d_a = xa; d_b = xb; d_mode = xm; d_iv = 1'b1;
    @(posedge clk);
    #1 d_iv = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int lat;
    lat = 0;
    while (!d_ov && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
  endtask

  task automatic do_op(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                       input bit xm, input logic [15:0] er, input bit ec, input bit eb,
                       input bit eo);
    issue(xa, xb, xm);
    wait_valid(nm);
    chk({nm, "_result"}, d_res, er);
    chk({nm, "_cout"}, d_co, ec);
    chk({nm, "_borrow"}, d_bo, eb);
    chk({nm, "_ovf"}, d_of, eo);
    @(posedge clk);
    #1 chk({nm, "_valid_drop"}, d_ov, 0);
  endtask

  // ---------------- random instances: 8/8 and 32/4 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int W = (g == 0) ? 8 : 32;
    localparam int C = (g == 0) ? 8 : 4;

    logic         iv_r, ordy_r, m_r, ir_r, ov_r, co_r, bo_r, of_r;
    logic [W-1:0] a_r, b_r, res_r;
    longint unsigned q_r[$];
    bit              q_c[$], q_b[$], q_o[$];
    int              pops;
    bit              done;

    chunk_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_valid (iv_r),
      .o_in_ready (ir_r),
      .i_a        (a_r),
      .i_b        (b_r),
      .i_mode     (m_r),
      .o_out_valid(ov_r),
      .i_out_ready(ordy_r),
      .o_result   (res_r),
      .o_cout     (co_r),
      .o_borrow   (bo_r),
      .o_ovf      (of_r)
    );

    initial begin
      ordy_r = 1'b1;
      wait (start);
      forever begin
        @(posedge clk);
        #1 ordy_r = ($urandom_range(3) != 0);
      end
    end

    initial begin
      int n;
      iv_r = 1'b0; m_r = 1'b0; a_r = '0; b_r = '0; pops = 0; done = 1'b0;
      wait (start);
      @(posedge clk);
      #1;
      for (int i = 0; i < NOPS; i++) begin
        if ($urandom_range(4) == 0) begin
          iv_r = 1'b0;
          @(posedge clk);
          #1;
        end
        a_r  = W'(pick(W));
        b_r  = W'(pick(W));
        m_r  = 1'($urandom_range(1));
        iv_r = 1'b1;
        n = 0;
        forever begin
          @(negedge clk);
          if (ir_r || n > 100) break;
          n++;
          @(posedge clk);
          #1;
        end
        if (!ir_r) begin
          chk($sformatf("w%0d_accept_timeout", W), ir_r, 1);
          break;
        end
        @(posedge clk);
        #1 iv_r = 1'b0;
      end
      iv_r = 1'b0;
      n = 0;
      while (pops < NOPS && n < 3000) begin
        @(posedge clk);
        n++;
      end
      chk($sformatf("w%0d_ops_done", W), pops, NOPS);
      done = 1'b1;
    end

    // Scoreboard: enqueue on accept, check every cycle out_valid is high
    always @(negedge clk) begin
      longint unsigned er;
      bit ec, eb, eo;
      if (rst_n) begin
        if (iv_r && ir_r) begin
          model(W, a_r, b_r, m_r, er, ec, eb, eo);
          q_r.push_back(er); q_c.push_back(ec); q_b.push_back(eb); q_o.push_back(eo);
        end
        if (ov_r) begin
          if (q_r.size() == 0) begin
            chk($sformatf("w%0d_spurious_valid", W), ov_r, 0);
          end else begin
            chk($sformatf("w%0d_result", W), res_r, q_r[0]);
            chk($sformatf("w%0d_cout", W), co_r, q_c[0]);
            chk($sformatf("w%0d_borrow", W), bo_r, q_b[0]);
            chk($sformatf("w%0d_ovf", W), of_r, q_o[0]);
            if (ordy_r) begin
              void'(q_r.pop_front()); void'(q_c.pop_front());
              void'(q_b.pop_front()); void'(q_o.pop_front());
              pops++;
            end
          end
        end
      end
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    longint unsigned mr;
    bit mc, mb, mo;

    rst_n = 1'b0; start = 1'b0;
    d_iv = 1'b0; d_ordy = 1'b1; d_mode = 1'b0; d_a = '0; d_b = '0;

    // Pin the reference model with hand-computed cases
    model(16, 64'h1234, 64'h0234, 1'b1, mr, mc, mb, mo);
    chk("model_sub_r", mr, 64'h1000); chk("model_sub_c", mc, 1); chk("model_sub_o", mo, 0);
    model(16, 64'h7FFF, 64'h0001, 1'b0, mr, mc, mb, mo);
    chk("model_add_r", mr, 64'h8000); chk("model_add_o", mo, 1); chk("model_add_c", mc, 0);
    model(8, 64'h80, 64'h80, 1'b0, mr, mc, mb, mo);
    chk("model_w8_r", mr, 0); chk("model_w8_c", mc, 1); chk("model_w8_o", mo, 1);
    model(32, 64'h0, 64'h1, 1'b1, mr, mc, mb, mo);
    chk("model_w32_r", mr, 64'hFFFF_FFFF); chk("model_w32_b", mb, 1); chk("model_w32_o", mo, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", d_ir, 0);
    chk("rst_out_valid", d_ov, 0);
    chk("rst_result", d_res, 0);
    chk("rst_flags", {d_co, d_bo, d_of}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", d_ir, 0);
    @(posedge clk);
    #1 chk("rel_in_ready_rise", d_ir, 1);

    do_op("sub_basic",  16'h1234, 16'h0234, 1'b1, 16'h1000, 1, 0, 0);
    do_op("sub_borrow", 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 0, 1, 0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 0, 1);
    do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 1);
    do_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 0);

    // Backpressure with input churn while DONE
    d_ordy = 1'b0;
    issue(16'h1234, 16'h0234, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      d_iv = 1'($urandom_range(1)); d_a = 16'($urandom()); d_b = 16'($urandom());
      d_mode = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      chk("bp_result", d_res, 16'h1000);
      chk("bp_in_ready", d_ir, 0);
      chk("bp_valid_held", d_ov, 1);
    end
    d_iv = 1'b0; d_ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", d_ov, 0);
    chk("bp_release_ready", d_ir, 1);
    chk("bp_result_hold", d_res, 16'h1000);
    @(posedge clk);
    #1 chk("bp_no_second", d_ov, 0);

    // Asynchronous reset after two BUSY cycles
    issue(16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", d_res, 0);
    chk("arst_cout", d_co, 0);
    chk("arst_valid", d_ov, 0);
    chk("arst_in_ready", d_ir, 0);
    #3 rst_n = 1'b1;
    #1 chk("arst_rel_ready", d_ir, 0);
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0);

    // Random sweeps on the other two configurations
    start = 1'b1;
    wait (g_rand[0].done && g_rand[1].done);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
